// File: rtl/div8_seq_if.sv
// Handshake and operand/result bundle for the sequential 8-bit divider.
interface div8_seq_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       dbz;

  modport master (output start, A, B, input Q, R, busy, done, dbz);
  modport slave  (input start, A, B, output Q, R, busy, done, dbz);
endinterface

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero skips the iteration and reports Q=FF, R=A with dbz set.
module div8_seq (
  input  logic       clk,
  input  logic       rst_n,
  div8_seq_if.slave  bus
);
  localparam int unsigned W = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_a, w_a_nxt;
  logic [W-1:0]    r_b, w_b_nxt;
  logic [W:0]      r_p, w_p_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [W-1:0]    r_q, w_q_nxt;
  logic [W-1:0]    r_quo, w_quo_nxt;
  logic [W-1:0]    r_rem, w_rem_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_dbz, w_dbz_nxt;

  logic            w_accept;
  logic [W:0]      w_p_shift;
  logic [W:0]      w_t;
  logic            w_bit;

  // Trial subtraction for the current iteration
  always_comb begin
    w_accept  = bus.start && (r_state != S_RUN);
    w_p_shift = {r_p[W-1:0], r_a[CW'(3'd7 - r_cnt)]};
    w_t       = w_p_shift + ~{1'b0, r_b} + (W+1)'(1);
    w_bit     = ~w_t[W];
  end

  // Next-state and next-value logic; all outputs are registered from these
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_p_nxt     = r_p;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_quo_nxt   = r_quo;
    w_rem_nxt   = r_rem;
    w_dbz_nxt   = r_dbz;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_RUN: begin
        w_p_nxt   = w_bit ? w_t : w_p_shift;
        w_q_nxt   = {r_q[W-2:0], w_bit};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(7)) begin
          w_state_nxt = S_DONE;
          w_quo_nxt   = {r_q[W-2:0], w_bit};
          w_rem_nxt   = w_p_nxt[W-1:0];
          w_done_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE share the accept path so a start in DONE chains cleanly
        if (w_accept) begin
          w_a_nxt   = bus.A;
          w_b_nxt   = bus.B;
          w_p_nxt   = '0;
          w_cnt_nxt = '0;
          w_q_nxt   = '0;
          w_dbz_nxt = 1'b0;
          if (bus.B == '0) begin
            w_state_nxt = S_DONE;
            w_quo_nxt   = '1;
            w_rem_nxt   = bus.A;
            w_dbz_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
            w_busy_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_p     <= w_p_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_quo   <= w_quo_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  assign bus.Q    = r_quo;
  assign bus.R    = r_rem;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.dbz  = r_dbz;
endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed vector table, hand-written corner
// sequences, and a chained sweep against a quotient/remainder reference.
module tb_div8_seq;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } op_t;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  op_t  q_ops[$];

  div8_seq_if u_if ();

  div8_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input op_t o);
    u_if.start = 1'b1;
    u_if.A     = o.a;
    u_if.B     = o.b;
  endtask

  function automatic op_t ref_op(input logic [7:0] a, input logic [7:0] b);
    op_t o;
    o.a = a;
    o.b = b;
    if (b == 8'd0) begin
      o.q = 8'hFF; o.r = a; o.dbz = 1'b1;
    end else begin
      o.q = a / b; o.r = a % b; o.dbz = 1'b0;
    end
    return o;
  endfunction

  // Issue every queued op; each one after the first is started in the DONE cycle
  task automatic run_queue();
    int lat;
    int nbusy;
    int last;
    if (q_ops.size() == 0) return;
    last = q_ops.size() - 1;
    @(negedge clk);
    drive(q_ops[0]);
    for (int i = 0; i < q_ops.size(); i++) begin
      @(posedge clk);
      @(negedge clk);
      u_if.start = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!u_if.done && lat < 20) begin
        nbusy += int'(u_if.busy);
        @(negedge clk);
        lat++;
      end
      chk("latency", 32'(lat), (q_ops[i].b == 8'd0) ? 32'd1 : 32'd9);
      chk("busy_cycles", 32'(nbusy), (q_ops[i].b == 8'd0) ? 32'd0 : 32'd8);
      chk("Q", 32'(u_if.Q), 32'(q_ops[i].q));
      chk("R", 32'(u_if.R), 32'(q_ops[i].r));
      chk("dbz", 32'(u_if.dbz), 32'(q_ops[i].dbz));
      if (i < last) drive(q_ops[i+1]);
    end
    @(negedge clk);
    chk("done_single_pulse", 32'(u_if.done), 32'd0);
    chk("Q_hold", 32'(u_if.Q), 32'(q_ops[last].q));
    chk("R_hold", 32'(u_if.R), 32'(q_ops[last].r));
    chk("dbz_hold", 32'(u_if.dbz), 32'(q_ops[last].dbz));
    q_ops.delete();
  endtask

  initial begin
    op_t vec [12];
    int  lat;
    int  ndone;

    vec = '{
      '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0},
      '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0},
      '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0},
      '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0},
      '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1},
      '{8'd9,   8'd3,   8'd3,   8'd0,   1'b0},
      '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0},
      '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0},
      '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0},
      '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0},
      '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1},
      '{8'd129, 8'd2,   8'd64,  8'd1,   1'b0}
    };

    u_if.start = 1'b0;
    u_if.A     = 8'd0;
    u_if.B     = 8'd0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_Q", 32'(u_if.Q), 32'd0);
    chk("rst_R", 32'(u_if.R), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_done", 32'(u_if.done), 32'd0);
    chk("rst_dbz", 32'(u_if.dbz), 32'd0);
    rst_n = 1'b1;

    // Each vector on its own from IDLE
    for (int i = 0; i < 12; i++) begin
      q_ops.push_back(vec[i]);
      run_queue();
    end
    // Same vectors chained back-to-back through DONE
    for (int i = 0; i < 12; i++) q_ops.push_back(vec[i]);
    run_queue();

    // Start during RUN must be ignored; operand changes while busy must not leak in
    @(negedge clk);
    drive('{8'd100, 8'd3, 8'd0, 8'd0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    lat = 1;
    repeat (3) begin @(negedge clk); lat++; end
    u_if.start = 1'b1; u_if.A = 8'd10; u_if.B = 8'd2;
    @(negedge clk); lat++;
    u_if.start = 1'b0; u_if.A = 8'hAA; u_if.B = 8'h55;
    while (!u_if.done && lat < 20) begin @(negedge clk); lat++; end
    chk("ignore_latency", 32'(lat), 32'd9);
    chk("ignore_Q", 32'(u_if.Q), 32'd33);
    chk("ignore_R", 32'(u_if.R), 32'd1);
    chk("ignore_dbz", 32'(u_if.dbz), 32'd0);

    // Asynchronous abort in RUN cycle 3
    @(negedge clk);
    drive('{8'd100, 8'd3, 8'd0, 8'd0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_Q", 32'(u_if.Q), 32'd0);
    chk("abort_R", 32'(u_if.R), 32'd0);
    chk("abort_busy", 32'(u_if.busy), 32'd0);
    chk("abort_done", 32'(u_if.done), 32'd0);
    chk("abort_dbz", 32'(u_if.dbz), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (14) begin @(negedge clk); ndone += int'(u_if.done); end
    chk("no_done_after_abort", 32'(ndone), 32'd0);

    // Start accepted on the very first edge after reset release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive('{8'd50, 8'd5, 8'd0, 8'd0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
    lat = 1;
    while (!u_if.done && lat < 20) begin @(negedge clk); lat++; end
    chk("post_rst_latency", 32'(lat), 32'd9);
    chk("post_rst_Q", 32'(u_if.Q), 32'd10);
    chk("post_rst_R", 32'(u_if.R), 32'd0);

    // Chained sweep: every A with B=0, a set of divisors over every A, and a strided grid
    for (int a = 0; a < 256; a++) q_ops.push_back(ref_op(8'(a), 8'd0));
    run_queue();
    begin
      logic [7:0] divs [15];
      divs = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd10, 8'd16, 8'd31, 8'd64,
               8'd100, 8'd127, 8'd128, 8'd200, 8'd254, 8'd255};
      for (int d = 0; d < 15; d++) begin
        for (int a = 0; a < 256; a++) q_ops.push_back(ref_op(8'(a), divs[d]));
        run_queue();
      end
    end
    for (int b = 4; b < 256; b += 7)
      for (int a = 3; a < 256; a += 17) q_ops.push_back(ref_op(8'(a), 8'(b)));
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
